// File: rtl/clint.sv
// clint: AXI4-Lite 64-bit mtime timer; define CLINT_WRITE_EN to make mtime writable
module clint #(
  parameter int unsigned            OFFSET_BITS = 16,
  parameter logic [OFFSET_BITS-1:0] MTIME_OFF   = 16'hBFF8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam logic [OFFSET_BITS-1:0] MTIME_HI = MTIME_OFF + OFFSET_BITS'(4);
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  r_state_t               r_state_q, r_state_d;
  w_state_t               w_state_q, w_state_d;
  logic [63:0]            mtime_q, mtime_d;
  logic [31:0]            shadow_q, shadow_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   aw_got_q, aw_got_d;
  logic                   w_got_q, w_got_d;
  logic [OFFSET_BITS-1:0] awaddr_q, awaddr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic [OFFSET_BITS-1:0] ar_off, wr_addr;
  logic [31:0]            wr_data, wr_mask;
  logic [3:0]             wr_strb;
  logic                   aw_hit, w_hit, wr_fire, wr_ok;
  assign arready = r_state_q == R_IDLE;
  assign rvalid  = r_state_q == R_RESP;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = w_state_q == W_IDLE && !aw_got_q;
  assign wready  = w_state_q == W_IDLE && !w_got_q;
  assign bvalid  = w_state_q == W_RESP;
  assign bresp   = bresp_q;
  assign ar_off  = araddr[OFFSET_BITS-1:0];
  assign aw_hit  = awvalid && awready;
  assign w_hit   = wvalid && wready;
  assign wr_addr = aw_got_q ? awaddr_q : awaddr[OFFSET_BITS-1:0];
  assign wr_data = w_got_q ? wdata_q : wdata;
  assign wr_strb = w_got_q ? wstrb_q : wstrb[3:0];
  assign wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
`ifdef CLINT_WRITE_EN
  assign wr_ok = wr_addr == MTIME_OFF || wr_addr == MTIME_HI;
`else
  assign wr_ok = 1'b0;
`endif
  // read channel: low-half read snapshots the high half so a following high read is coherent
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    shadow_d  = shadow_q;
    if (r_state_q == R_IDLE) begin
      if (arvalid) begin
        r_state_d = R_RESP;
        rresp_d   = (ar_off == MTIME_OFF || ar_off == MTIME_HI) ? 2'b00 : 2'b10;
        rdata_d   = ar_off == MTIME_OFF ? mtime_q[31:0] : ar_off == MTIME_HI ? shadow_q : 32'd0;
        shadow_d  = ar_off == MTIME_OFF ? mtime_q[63:32] : shadow_q;
      end
    end else if (rready) begin
      r_state_d = R_IDLE;
    end
  end
  // write channel: AW and W are captured independently, the write fires once both are held
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    wr_fire   = 1'b0;
    if (w_state_q == W_IDLE) begin
      if (aw_hit) begin
        aw_got_d = 1'b1;
        awaddr_d = awaddr[OFFSET_BITS-1:0];
      end
      if (w_hit) begin
        w_got_d = 1'b1;
        wdata_d = wdata;
        wstrb_d = wstrb[3:0];
      end
      if ((aw_got_q || aw_hit) && (w_got_q || w_hit)) begin
        wr_fire   = 1'b1;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
        w_state_d = W_RESP;
        bresp_d   = wr_ok ? 2'b00 : 2'b10;
      end
    end else if (bready) begin
      w_state_d = W_IDLE;
    end
  end
  // mtime: free-running increment, replaced by a byte-masked write on the write cycle
  always_comb begin
    mtime_d = mtime_q + 64'd1;
    if (wr_fire && wr_ok)
      mtime_d = wr_addr == MTIME_OFF
        ? {mtime_q[63:32], (mtime_q[31:0] & ~wr_mask) | (wr_data & wr_mask)}
        : {(mtime_q[63:32] & ~wr_mask) | (wr_data & wr_mask), mtime_q[31:0]};
  end
  // state registers; reset drops any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      mtime_q   <= '0;
      shadow_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      bresp_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      mtime_q   <= mtime_d;
      shadow_q  <= shadow_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end
endmodule

// File: tb/tb_clint.sv
// tb_clint: directed checks of the clint read/write channels, shadow and reset behaviour
module tb_clint;
`ifdef CLINT_WRITE_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [7:0]  wstrb = '0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic [63:0] cyc, off;
  int          checks = 0, errors = 0;

  clint dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // reference count of clock edges since reset; expected mtime is cyc + off
  always @(posedge clk or posedge rst) cyc <= rst ? 64'd0 : cyc + 64'd1;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // records the effect of a write fired at the edge following cycle count c
  task automatic model_write(input logic [63:0] c, input bit hi, input logic [31:0] d, input logic [3:0] s);
    logic [63:0] v;
    logic [31:0] m;
    v = c + off;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (hi) v[63:32] = (v[63:32] & ~m) | (d & m);
    else v[31:0] = (v[31:0] & ~m) | (d & m);
    if (WEN) off = v - (c + 64'd1);
  endtask

  task automatic rd_issue(input logic [31:0] a, output logic [63:0] e);
    e = cyc + off;
    arvalid = 1'b1;
    araddr = a;
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic rd_finish;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic b_finish;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({arready, awready, wready} !== 3'b111) begin errors++; $display("FAIL reset_readies got %b want 111", {arready, awready, wready}); end
    checks++;
    if ({rvalid, bvalid} !== 2'b00) begin errors++; $display("FAIL reset_valids got %b want 00", {rvalid, bvalid}); end
    checks++;
    if ({rdata, rresp, bresp} !== 36'd0) begin errors++; $display("FAIL reset_data got %h want 0", {rdata, rresp, bresp}); end
    rst = 1'b0;
    off = '0;
  endtask

  task automatic test_read_latency;
    repeat (10) @(negedge clk);
    checks++;
    if ({arready, rvalid} !== 2'b10) begin errors++; $display("FAIL lat_idle got %b want 10", {arready, rvalid}); end
    arvalid = 1'b1;
    araddr = 32'h0000_BFF8;
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("FAIL lat_rvalid got %b want 1", rvalid); end
    checks++;
    if (rdata !== 32'd10) begin errors++; $display("FAIL lat_rdata got %0d want 10", rdata); end
    checks++;
    if (rresp !== 2'b00) begin errors++; $display("FAIL lat_rresp got %b want 00", rresp); end
    rd_finish;
    checks++;
    if ({arready, rvalid} !== 2'b10) begin errors++; $display("FAIL lat_done got %b want 10", {arready, rvalid}); end
  endtask

  task automatic test_shadow;
    logic [63:0] e, e2, e3;
    rd_issue(32'h0000_BFF8, e);
    checks++;
    if (rdata !== e[31:0]) begin errors++; $display("FAIL shadow_lo got %h want %h", rdata, e[31:0]); end
    rd_finish;
    repeat (100) @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h0000_BFFC; wdata = 32'h77; wstrb = 8'h0F;
    e2 = cyc;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(e2, 1'b1, 32'h77, 4'hF);
    b_finish;
    rd_issue(32'h0000_BFFC, e2);
    checks++;
    if (rdata !== e[63:32]) begin errors++; $display("FAIL shadow_hi_old got %h want %h", rdata, e[63:32]); end
    rd_finish;
    rd_issue(32'h0000_BFF8, e3);
    rd_finish;
    rd_issue(32'h0000_BFFC, e2);
    checks++;
    if (rdata !== e3[63:32]) begin errors++; $display("FAIL shadow_hi_new got %h want %h", rdata, e3[63:32]); end
    rd_finish;
  endtask

  task automatic test_rready_hold;
    logic [63:0] e;
    rd_issue(32'h0000_BFF8, e);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rvalid, arready} !== 2'b10) begin errors++; $display("FAIL hold_hs%0d got %b want 10", i, {rvalid, arready}); end
      checks++;
      if (rdata !== e[31:0]) begin errors++; $display("FAIL hold_rdata%0d got %h want %h", i, rdata, e[31:0]); end
      @(negedge clk);
    end
    rready = 1'b1;
    checks++;
    if (arready !== 1'b0) begin errors++; $display("FAIL hold_arready_hs got %b want 0", arready); end
    @(negedge clk);
    rready = 1'b0;
    checks++;
    if ({arready, rvalid} !== 2'b10) begin errors++; $display("FAIL hold_after got %b want 10", {arready, rvalid}); end
  endtask

  task automatic test_bad_addr;
    logic [63:0] e;
    rd_issue(32'h0000_0000, e);
    checks++;
    if ({rdata, rresp} !== {32'd0, 2'b10}) begin errors++; $display("FAIL bad_zero got %h/%b want 0/10", rdata, rresp); end
    rd_finish;
    rd_issue(32'h0000_BFF4, e);
    checks++;
    if ({rdata, rresp} !== {32'd0, 2'b10}) begin errors++; $display("FAIL bad_bff4 got %h/%b want 0/10", rdata, rresp); end
    rd_finish;
    rd_issue(32'hFFFF_BFF8, e);
    checks++;
    if ({rdata, rresp} !== {e[31:0], 2'b00}) begin errors++; $display("FAIL upper_ignored got %h/%b want %h/00", rdata, rresp, e[31:0]); end
    rd_finish;
  endtask

  task automatic test_write_split;
    logic [63:0] c, e;
    awvalid = 1'b1; awaddr = 32'h0000_BFF8;
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if ({awready, wready, bvalid} !== 3'b010) begin errors++; $display("FAIL split_aw got %b want 010", {awready, wready, bvalid}); end
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL split_wait got %b want 0", bvalid); end
    wvalid = 1'b1; wdata = 32'h0000_1234; wstrb = 8'h0F;
    c = cyc;
    @(negedge clk);
    wvalid = 1'b0;
    model_write(c, 1'b0, 32'h1234, 4'hF);
    checks++;
    if ({bvalid, bresp} !== {1'b1, WEN ? 2'b00 : 2'b10}) begin errors++; $display("FAIL split_b got %b/%b want 1/%b", bvalid, bresp, WEN ? 2'b00 : 2'b10); end
    checks++;
    if ({awready, wready} !== 2'b00) begin errors++; $display("FAIL split_resp_rdy got %b want 00", {awready, wready}); end
    b_finish;
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin errors++; $display("FAIL split_done got %b want 011", {bvalid, awready, wready}); end
    rd_issue(32'h0000_BFF8, e);
    checks++;
    if (rdata !== e[31:0]) begin errors++; $display("FAIL split_readback got %h want %h", rdata, e[31:0]); end
    rd_finish;
  endtask

  task automatic test_w_before_aw;
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 8'h0F;
    @(negedge clk);
    wvalid = 1'b0;
    checks++;
    if ({awready, wready, bvalid} !== 3'b100) begin errors++; $display("FAIL wfirst_w got %b want 100", {awready, wready, bvalid}); end
    awvalid = 1'b1; awaddr = 32'h0000_0000;
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if ({bvalid, bresp} !== 3'b110) begin errors++; $display("FAIL wfirst_b got %b/%b want 1/10", bvalid, bresp); end
    b_finish;
  endtask

  task automatic test_same_cycle_hi;
    logic [63:0] c, e;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h0000_BFFC; wdata = 32'hAABB_CCDD; wstrb = 8'hF5;
    c = cyc;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(c, 1'b1, 32'hAABB_CCDD, 4'h5);
    checks++;
    if ({bvalid, bresp} !== {1'b1, WEN ? 2'b00 : 2'b10}) begin errors++; $display("FAIL same_b got %b/%b want 1/%b", bvalid, bresp, WEN ? 2'b00 : 2'b10); end
    b_finish;
    rd_issue(32'h0000_BFF8, e);
    rd_finish;
    rd_issue(32'h0000_BFFC, c);
    checks++;
    if (rdata !== (WEN ? 32'h00BB_00DD : 32'd0)) begin errors++; $display("FAIL same_hi got %h want %h", rdata, WEN ? 32'h00BB_00DD : 32'd0); end
    checks++;
    if (rdata !== e[63:32]) begin errors++; $display("FAIL same_hi_model got %h want %h", rdata, e[63:32]); end
    rd_finish;
  endtask

  task automatic test_concurrent;
    logic [63:0] c, e;
    arvalid = 1'b1; araddr = 32'h0000_BFF8;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h0000_BFF8; wdata = 32'h0000_5000; wstrb = 8'h0F;
    c = cyc;
    e = cyc + off;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    model_write(c, 1'b0, 32'h5000, 4'hF);
    checks++;
    if ({rvalid, bvalid} !== 2'b11) begin errors++; $display("FAIL conc_valid got %b want 11", {rvalid, bvalid}); end
    checks++;
    if (rdata !== e[31:0]) begin errors++; $display("FAIL conc_prewrite got %h want %h", rdata, e[31:0]); end
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    rd_issue(32'h0000_BFF8, e);
    checks++;
    if (rdata !== e[31:0]) begin errors++; $display("FAIL conc_after got %h want %h", rdata, e[31:0]); end
    rd_finish;
  endtask

  task automatic test_reset_inflight;
    logic [63:0] e;
    rd_issue(32'h0000_BFF8, e);
    awvalid = 1'b1; awaddr = 32'h0000_BFF8;
    @(negedge clk);
    awvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rvalid, bvalid, rdata} !== 34'd0) begin errors++; $display("FAIL rst_now got %b/%b/%h want 0/0/0", rvalid, bvalid, rdata); end
    checks++;
    if ({arready, awready, wready} !== 3'b111) begin errors++; $display("FAIL rst_readies got %b want 111", {arready, awready, wready}); end
    @(negedge clk);
    rst = 1'b0;
    off = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rvalid, bvalid} !== 2'b00) begin errors++; $display("FAIL rst_noresp%0d got %b want 00", i, {rvalid, bvalid}); end
    end
    arvalid = 1'b1; araddr = 32'h0000_BFF8;
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if ({rvalid, rdata} !== {1'b1, 32'd3}) begin errors++; $display("FAIL rst_mtime got %b/%0d want 1/3", rvalid, rdata); end
    rd_finish;
  endtask

  initial begin
    test_reset;
    test_read_latency;
    test_shadow;
    test_rready_hold;
    test_bad_addr;
    test_write_split;
    test_w_before_aw;
    test_same_cycle_hi;
    test_concurrent;
    test_reset_inflight;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
